// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// No logic of its own; no latency.
// Not applicable for backpressure; consumers define their own flow control.
package imem_pkg;

  // Returned on error responses: addi x0,x0,0.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // One buffered response: error flag plus instruction word.
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  // Occupancy of the 2-entry response buffer; the encoding equals the count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Number of index bits needed to address a word array of the given depth.
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_responder_rsp_fifo2.sv
// Two-entry in-order response FIFO with push, pop, clear and head view.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is ignored when full; clear drops old entries but keeps a same-cycle push.
module rsp_fifo2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_t       push_dat,
  input  logic       pop,
  input  logic       clear,
  output logic [1:0] count,
  output rsp_t       head
);

  buf_state_t state_q, state_d;
  rsp_t       entry_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       push_ok;
  logic       pop_ok;

  // A push into a full buffer or a pop from an empty one has no effect.
  assign push_ok = push && (state_q != FULL);
  assign pop_ok  = pop && (state_q != EMPTY);

  // Occupancy and pointer registers; reset empties the buffer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Next occupancy: clear wins over pop but yields to push, so the
  // incoming (post-redirect) entry survives as the sole new head.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_ok) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (clear) begin
      // New head is wherever the next write lands (or would land).
      rd_ptr_d = wr_ptr_q;
      state_d  = push_ok ? ONE : EMPTY;
    end else begin
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case (state_q)
        EMPTY: if (push_ok) state_d = ONE;
        ONE: begin
          if (push_ok && !pop_ok)      state_d = FULL;
          else if (!push_ok && pop_ok) state_d = EMPTY;
        end
        FULL:    if (pop_ok) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry storage; cleared on reset so an idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
    end else if (push_ok) begin
      entry_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head  = entry_q[rd_ptr_q];
  assign count = state_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch requests in, instruction words out, plus a preload write port.
// Latency: response valid the cycle after the accepting edge; no combinational request-to-response path.
// Backpressure: 2-entry response buffer; req_ready comes only from registered occupancy.
module imem_responder #(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [31:0]      wr_data
);

  import imem_pkg::*;

  localparam int IDX_W = idx_w(DEPTH_WORDS);

  // Instruction store: not reset, contents survive rst_n.
  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             req_err;
  logic             wr_bad;
  logic             req_fire;
  logic             pop;
  logic [1:0]       count;
  rsp_t             push_dat;
  rsp_t             head;

  assign req_idx = req_addr[IDX_W+1:2];
  assign wr_idx  = wr_addr[IDX_W+1:2];

  // Misaligned, or any address bit above the array span set.
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[WIDTH-1:IDX_W+2] != '0);
  assign wr_bad  = (wr_addr[1:0] != 2'b00) || (wr_addr[WIDTH-1:IDX_W+2] != '0);

  assign req_ready = (count != 2'd2);
  assign req_fire  = req_valid && req_ready;

  // A pop in a flush cycle is void: the flushed head is never consumed.
  assign pop = rsp_valid && rsp_ready && !flush;

  // Response word: the array is read before this edge's preload write lands,
  // which gives read-before-write on a same-word collision.
  always_comb begin
    push_dat.err  = req_err;
    push_dat.data = NOP_WORD;
    if (!req_err) begin
      push_dat.data = mem[req_idx];
    end
  end

  // Preload port; bad addresses are silently dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bad) begin
      mem[wr_idx] <= wr_data;
    end
  end

  rsp_fifo2 u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_fire),
    .push_dat (push_dat),
    .pop      (pop),
    .clear    (flush),
    .count    (count),
    .head     (head)
  );

  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = head.data;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .WIDTH       (32),
    .DEPTH_WORDS (256),
    .NOP_WORD    (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        fl;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_err;
  } vec_t;

  vec_t vt[$];

  typedef struct {
    logic        err;
    logic [31:0] data;
  } mrsp_t;

  mrsp_t       mq[$];
  logic [31:0] mmem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                      input logic er, input logic ev, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
    v.e_rdy = er; v.e_vld = ev; v.e_dat = ed; v.e_err = ee;
    vt.push_back(v);
  endtask

  function automatic logic [31:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h400 + ($urandom & 32'h0FFF_FFFC);
    if (sel == 1) return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
    return $urandom_range(0, 255) << 2;
  endfunction

  initial begin
    logic  exp_rdy;
    logic  exp_vld;
    logic  acc;
    logic  a_bad;
    mrsp_t r;
    int    ia;

    // Reset state while rst_n is held low.
    #2;
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload words 0..3.
    addv(1, 32'h0, 32'h11111111, 0, 0, 1, 0, 1, 0, 0, 0);
    addv(1, 32'h4, 32'h22222222, 0, 0, 1, 0, 1, 0, 0, 0);
    addv(1, 32'h8, 32'h33333333, 0, 0, 1, 0, 1, 0, 0, 0);
    addv(1, 32'hC, 32'h44444444, 0, 0, 1, 0, 1, 0, 0, 0);
    // Back-to-back streaming at full throughput.
    addv(0, 0, 0, 1, 32'h0, 1, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h4, 1, 0, 1, 1, 32'h11111111, 0);
    addv(0, 0, 0, 1, 32'h8, 1, 0, 1, 1, 32'h22222222, 0);
    addv(0, 0, 0, 1, 32'hC, 1, 0, 1, 1, 32'h33333333, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 1, 32'h44444444, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 0, 0, 0);
    // Fill under backpressure, third request stalls, then drains in order.
    addv(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h4, 0, 0, 1, 1, 32'h11111111, 0);
    addv(0, 0, 0, 1, 32'h8, 0, 0, 0, 1, 32'h11111111, 0);
    addv(0, 0, 0, 1, 32'h8, 1, 0, 0, 1, 32'h11111111, 0);
    addv(0, 0, 0, 1, 32'h8, 1, 0, 1, 1, 32'h22222222, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 1, 32'h33333333, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 0, 0, 0);
    // Misaligned and out-of-range requests.
    addv(0, 0, 0, 1, 32'h6,   1, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h400, 1, 0, 1, 1, 32'h13, 1);
    addv(0, 0, 0, 0, 0,       1, 0, 1, 1, 32'h13, 1);
    addv(0, 0, 0, 0, 0,       1, 0, 1, 0, 0, 0);
    // Flush with one buffered entry and a same-cycle accepted request.
    addv(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h8, 0, 1, 1, 1, 32'h11111111, 0);
    addv(0, 0, 0, 0, 0,     0, 0, 1, 1, 32'h33333333, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 1, 32'h33333333, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 0, 0, 0);
    // Flush with the buffer full: request cannot be taken, pop is void.
    addv(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h4, 0, 0, 1, 1, 32'h11111111, 0);
    addv(0, 0, 0, 1, 32'h8, 1, 1, 0, 1, 32'h11111111, 0);
    addv(0, 0, 0, 1, 32'h8, 0, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 1, 32'h33333333, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 0, 0, 0);
    // Same-cycle read and write to one word: old data first.
    addv(1, 32'h4, 32'hDEADBEEF, 1, 32'h4, 1, 0, 1, 0, 0, 0);
    addv(0, 0, 0,                1, 32'h4, 1, 0, 1, 1, 32'h22222222, 0);
    addv(0, 0, 0,                0, 0,     1, 0, 1, 1, 32'hDEADBEEF, 0);
    addv(0, 0, 0,                0, 0,     1, 0, 1, 0, 0, 0);
    // Out-of-range and misaligned writes must not touch word 0.
    addv(1, 32'h400, 32'hBAD0BAD0, 0, 0, 1, 0, 1, 0, 0, 0);
    addv(1, 32'h1,   32'h0BADF00D, 0, 0, 1, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 1, 32'h0, 1, 0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 1, 32'h11111111, 0);
    addv(0, 0, 0, 0, 0,     1, 0, 1, 0, 0, 0);

    foreach (vt[i]) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      req_valid = vt[i].rv; req_addr = vt[i].ra;
      rsp_ready = vt[i].rr; flush = vt[i].fl;
      #4;
      chk($sformatf("v%0d req_ready", i), {31'b0, req_ready}, {31'b0, vt[i].e_rdy});
      chk($sformatf("v%0d rsp_valid", i), {31'b0, rsp_valid}, {31'b0, vt[i].e_vld});
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d rsp_data", i), rsp_data, vt[i].e_dat);
        chk($sformatf("v%0d rsp_err", i), {31'b0, rsp_err}, {31'b0, vt[i].e_err});
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; req_valid = 1'b0; flush = 1'b0;

    // Asynchronous reset between edges with one entry buffered.
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("pre-reset rsp_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async reset req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3;
    chk("post-reset rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("post-reset rsp_data", rsp_data, 32'h11111111);
    @(posedge clk); #1;

    // Randomized traffic against a queue-and-array reference.
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = i << 2; wr_data = $urandom;
      mmem[i] = wr_data;
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    mq.delete();

    for (int c = 0; c < 3000; c++) begin
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = pick_addr();
      wr_data   = $urandom;
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = pick_addr();
      rsp_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      #4;
      exp_rdy = (mq.size() < 2);
      exp_vld = (mq.size() > 0);
      chk($sformatf("rnd%0d req_ready", c), {31'b0, req_ready}, {31'b0, exp_rdy});
      chk($sformatf("rnd%0d rsp_valid", c), {31'b0, rsp_valid}, {31'b0, exp_vld});
      if (exp_vld) begin
        chk($sformatf("rnd%0d rsp_data", c), rsp_data, mq[0].data);
        chk($sformatf("rnd%0d rsp_err", c), {31'b0, rsp_err}, {31'b0, mq[0].err});
      end
      acc = req_valid && exp_rdy;
      a_bad = (req_addr % 4 != 0) || (req_addr >= 32'd1024);
      r.err = a_bad;
      r.data = 32'h13;
      if (!a_bad) begin
        ia = int'(req_addr / 4);
        r.data = mmem[ia];
      end
      if (flush) mq.delete();
      else if (exp_vld && rsp_ready) void'(mq.pop_front());
      if (acc) mq.push_back(r);
      if (wr_en && (wr_addr % 4 == 0) && (wr_addr < 32'd1024)) begin
        ia = int'(wr_addr / 4);
        mmem[ia] = wr_data;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
